multicycle_sequencer: RTL

- Phase sequencer for the multi-cycle version of our KGP-RISC datapath.
- Consumes the decoded control lines from control_unit (regWrite, memRead, memWrite, branch, jumpAddr, halt decode) and converts them into per-phase strobes: IR load, PC load, register-file write and memory request.
- Owns the single-port unified memory handshake, so instruction fetch and data access share one memory.

---
 rtl/seq_pkg.sv | 28 ++
 rtl/seq_perf_counter.sv | 19 +
 rtl/multicycle_sequencer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the KGP-RISC multi-cycle phase sequencer.
package seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6
  } state_t;

  // Decoded control lines captured in DECODE and used through EXEC/MEM/WB.
  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic jump;
  } dec_flags_t;

  localparam logic PC_SEQ   = 1'b0;
  localparam logic PC_TGT   = 1'b1;
  localparam logic ADDR_PC  = 1'b0;
  localparam logic ADDR_ALU = 1'b1;

endpackage

// File: rtl/seq_perf_counter.sv
// Free-running wrap-around counter with enable, used for sequencer performance counts.
module seq_perf_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Phase sequencer for the multi-cycle KGP-RISC datapath; owns the unified memory handshake.
// Optional performance counters are built when SEQ_PERF_CNT_EN is defined.
module multicycle_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dec_reg_write,
  input  logic             dec_mem_read,
  input  logic             dec_mem_write,
  input  logic             dec_branch,
  input  logic             dec_jump,
  input  logic             dec_halt,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             ir_load,
  output logic             pc_load,
  output logic             pc_sel,
  output logic             rf_we,
  output logic             instr_done,
  output logic             halted,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  // Memory waits are unbounded; a nonzero timeout has no implementation.
  if (MEM_TIMEOUT != 0) begin : g_bad_timeout
    $error("multicycle_sequencer: MEM_TIMEOUT must be 0");
  end

  state_t     state_q, state_d;
  dec_flags_t flags_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Decode lines are only trusted in DECODE; hold them for the rest of the instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else if (state_q == DECODE) begin
      flags_q <= '{reg_write: dec_reg_write, mem_read: dec_mem_read,
                   mem_write: dec_mem_write, branch: dec_branch, jump: dec_jump};
    end
  end

  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    addr_sel   = ADDR_PC;
    ir_load    = 1'b0;
    pc_load    = 1'b0;
    pc_sel     = PC_SEQ;
    rf_we      = 1'b0;
    instr_done = 1'b0;
    halted     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = FETCH;
      end
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_load = 1'b1;
          pc_load = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        state_d = dec_halt ? HALT : EXEC;
      end
      EXEC: begin
        // Control transfer outranks memory and ALU work; a set reg_write means link.
        if (flags_q.branch || flags_q.jump) begin
          pc_sel  = PC_TGT;
          pc_load = flags_q.jump | (flags_q.branch & branch_taken);
          if (flags_q.reg_write) begin
            state_d = WB;
          end else begin
            instr_done = 1'b1;
            state_d    = FETCH;
          end
        end else if (flags_q.mem_write || flags_q.mem_read) begin
          state_d = MEM;
        end else if (flags_q.reg_write) begin
          state_d = WB;
        end else begin
          instr_done = 1'b1;
          state_d    = FETCH;
        end
      end
      MEM: begin
        mem_req  = 1'b1;
        addr_sel = ADDR_ALU;
        mem_we   = flags_q.mem_write;
        if (mem_ready) begin
          if (flags_q.mem_write) begin
            instr_done = 1'b1;
            state_d    = FETCH;
          end else begin
            state_d = WB;
          end
        end
      end
      WB: begin
        rf_we      = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign state = 3'(state_q);

`ifdef SEQ_PERF_CNT_EN
  logic cycle_en;
  assign cycle_en = (state_q != IDLE) && (state_q != HALT);

  seq_perf_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (cycle_en),
    .count (cycle_count)
  );

  seq_perf_counter #(.CNT_W(CNT_W)) u_instr_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (instr_done),
    .count (instr_count)
  );
`else
  assign cycle_count = '0;
  assign instr_count = '0;
`endif

endmodule
